// File: rtl/ioctl_rom_loader.sv
// rtl/ioctl_rom_loader.sv - ioctl ROM/DIP download engine with region decode, word packing and back-pressure
module ioctl_rom_loader #(
   parameter int                         NUM_REGIONS = 4,
   // region 0 sits in the LSBs: 32K, 32K, 16K, 8K
   parameter logic [5*NUM_REGIONS-1:0]   REGION_BITS = {5'd13, 5'd14, 5'd15, 5'd15},
   parameter int                         DATA_WIDTH  = 8,
   parameter int                         ADDR_WIDTH  = 16,
   parameter logic [15:0]                ROM_INDEX   = 16'd0,
   parameter logic [15:0]                DIP_INDEX   = 16'd254,
   parameter int                         DIP_BYTES   = 2,
   parameter logic [8*DIP_BYTES-1:0]     DIP_DEFAULT = '0
) (
   input  logic                      i_EMU_MCLK,
   input  logic                      i_EMU_INITRST_n,
   input  logic [15:0]               ioctl_index,
   input  logic                      ioctl_download,
   input  logic [26:0]               ioctl_addr,
   input  logic [7:0]                ioctl_data,
   input  logic                      ioctl_wr,
   output logic                      ioctl_wait,
   output logic [ADDR_WIDTH-1:0]     o_ROM_ADDR,
   output logic [DATA_WIDTH-1:0]     o_ROM_DATA,
   output logic [NUM_REGIONS-1:0]    o_ROM_WR,
   input  logic [NUM_REGIONS-1:0]    i_ROM_BUSY,
   output logic [8*DIP_BYTES-1:0]    o_DIP,
   output logic                      o_LOADING,
   output logic                      o_DONE,
   output logic                      o_ERR
);
   localparam int BPW = DATA_WIDTH / 8;
   localparam int SH  = (BPW == 2) ? 1 : 0;
   localparam int RW  = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
   localparam int AW  = 40;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_COLLECT = 3'd1;
   localparam logic [2:0] S_ISSUE   = 3'd2;
   localparam logic [2:0] S_FLUSH   = 3'd3;
   localparam logic [2:0] S_FINISH  = 3'd4;

   function automatic logic [AW-1:0] region_size(int k);
      return AW'(1) << REGION_BITS[5*k +: 5];
   endfunction

   function automatic logic [AW-1:0] region_base(int k);
      logic [AW-1:0] b;
      b = '0;
      for (int j = 0; j < k; j++) b = b + region_size(j);
      return b;
   endfunction

   logic [2:0]            state;
   logic                  dl_q;
   logic [DATA_WIDTH-1:0] word_buf;
   logic                  pending;
   logic [RW-1:0]         tgt_region;
   logic [ADDR_WIDTH-1:0] tgt_addr;

   logic                  hit;
   logic [RW-1:0]         hit_region;
   logic [AW-1:0]         offset;
   logic [AW-1:0]         addr_ext;
   logic                  lane_last;
   logic                  rom_wr;

   assign addr_ext  = AW'(ioctl_addr);
   assign rom_wr    = ioctl_wr && (ioctl_index == ROM_INDEX);
   assign lane_last = (BPW == 1) ? 1'b1 : offset[0];

   always_comb begin
      hit        = 1'b0;
      hit_region = '0;
      offset     = '0;
      for (int k = 0; k < NUM_REGIONS; k++) begin
         if (!hit && addr_ext >= region_base(k) && addr_ext < region_base(k) + region_size(k)) begin
            hit        = 1'b1;
            hit_region = RW'(k);
            offset     = addr_ext - region_base(k);
         end
      end
   end

   // dl_q resets high so a download still active across reset is not taken as a new start
   always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
      if (!i_EMU_INITRST_n) begin
         state      <= S_IDLE;
         dl_q       <= 1'b1;
         word_buf   <= '0;
         pending    <= 1'b0;
         tgt_region <= '0;
         tgt_addr   <= '0;
         ioctl_wait <= 1'b0;
         o_ROM_ADDR <= '0;
         o_ROM_DATA <= '0;
         o_ROM_WR   <= '0;
         o_DIP      <= DIP_DEFAULT;
         o_LOADING  <= 1'b1;
         o_DONE     <= 1'b0;
         o_ERR      <= 1'b0;
      end else begin
         dl_q     <= ioctl_download;
         o_ROM_WR <= '0;

         for (int b = 0; b < DIP_BYTES; b++) begin
            if (ioctl_wr && ioctl_index == DIP_INDEX && ioctl_addr == 27'(b))
               o_DIP[8*b +: 8] <= ioctl_data;
         end

         case (state)
            S_IDLE: begin
               if (ioctl_download && !dl_q && ioctl_index == ROM_INDEX) begin
                  state     <= S_COLLECT;
                  o_LOADING <= 1'b1;
                  o_DONE    <= 1'b0;
                  o_ERR     <= 1'b0;
                  word_buf  <= '0;
                  pending   <= 1'b0;
               end
            end
            S_COLLECT: begin
               ioctl_wait <= 1'b0;
               if (rom_wr) begin
                  if (!hit) begin
                     o_ERR <= 1'b1;
                  end else begin
                     for (int l = 0; l < BPW; l++) begin
                        if (BPW == 1 || offset[0] == l[0]) word_buf[8*l +: 8] <= ioctl_data;
                     end
                     tgt_region <= hit_region;
                     tgt_addr   <= ADDR_WIDTH'(offset >> SH);
                     pending    <= 1'b1;
                     if (lane_last) begin
                        state      <= S_ISSUE;
                        ioctl_wait <= 1'b1;
                     end
                  end
               end else if (!ioctl_download) begin
                  if (pending) begin
                     state      <= S_FLUSH;
                     ioctl_wait <= 1'b1;
                  end else begin
                     state <= S_FINISH;
                  end
               end
            end
            S_ISSUE, S_FLUSH: begin
               if (rom_wr) o_ERR <= 1'b1;
               if (!i_ROM_BUSY[tgt_region]) begin
                  o_ROM_WR   <= NUM_REGIONS'(1) << tgt_region;
                  o_ROM_ADDR <= tgt_addr;
                  o_ROM_DATA <= word_buf;
                  word_buf   <= '0;
                  pending    <= 1'b0;
                  state      <= (state == S_FLUSH) ? S_FINISH : S_COLLECT;
               end
            end
            S_FINISH: begin
               ioctl_wait <= 1'b0;
               o_LOADING  <= 1'b0;
               o_DONE     <= 1'b1;
               state      <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
